// File: rtl/operand_fetch_if.sv
// Decode, register-file, writeback and execute signals of the operand-fetch stage.
// The slave modport is the stage itself; the master modport is its surroundings.
interface operand_fetch_if #(
    parameter int PAYLOAD_W = 32
);
    logic                 in_valid;
    logic                 in_ready;
    logic [4:0]           in_rs1;
    logic [4:0]           in_rs2;
    logic                 in_rs1_en;
    logic                 in_rs2_en;
    logic [4:0]           in_rd;
    logic                 in_rd_en;
    logic [PAYLOAD_W-1:0] in_payload;

    logic                 rf_rd_en1;
    logic                 rf_rd_en2;
    logic [4:0]           rf_rd_addr1;
    logic [4:0]           rf_rd_addr2;
    logic [31:0]          rf_rd_data1;
    logic [31:0]          rf_rd_data2;

    logic                 wb_en;
    logic [4:0]           wb_addr;
    logic [31:0]          wb_data;

    logic                 out_valid;
    logic                 out_ready;
    logic [31:0]          out_op1;
    logic [31:0]          out_op2;
    logic [4:0]           out_rd;
    logic                 out_rd_en;
    logic [PAYLOAD_W-1:0] out_payload;

    modport slave (
        input  in_valid, in_rs1, in_rs2, in_rs1_en, in_rs2_en, in_rd, in_rd_en, in_payload,
        output in_ready,
        output rf_rd_en1, rf_rd_en2, rf_rd_addr1, rf_rd_addr2,
        input  rf_rd_data1, rf_rd_data2,
        input  wb_en, wb_addr, wb_data,
        output out_valid, out_op1, out_op2, out_rd, out_rd_en, out_payload,
        input  out_ready
    );

    modport master (
        output in_valid, in_rs1, in_rs2, in_rs1_en, in_rs2_en, in_rd, in_rd_en, in_payload,
        input  in_ready,
        input  rf_rd_en1, rf_rd_en2, rf_rd_addr1, rf_rd_addr2,
        output rf_rd_data1, rf_rd_data2,
        output wb_en, wb_addr, wb_data,
        input  out_valid, out_op1, out_op2, out_rd, out_rd_en, out_payload,
        output out_ready
    );
endinterface

// File: rtl/operand_fetch.sv
// Register-read/issue stage: scoreboard hazard stall, optional writeback forwarding
// (OPFETCH_BYPASS_EN), 1-cycle latency, held output stalls decode while execute is not ready.
// Backpressure: in_ready drops on RAW/WAW hazard or when the output slot is full and not draining.
module operand_fetch #(
    parameter int PAYLOAD_W = 32
) (
    input  logic           clk,
    input  logic           rst,
    operand_fetch_if.slave bus
);
    // Register 0 never holds a pending write, so only bits 31..1 are stored.
    logic [31:1]          r_busy;
    logic                 r_out_valid;
    logic [31:0]          r_op1;
    logic [31:0]          r_op2;
    logic [4:0]           r_rd;
    logic                 r_rd_en;
    logic [PAYLOAD_W-1:0] r_payload;

    logic [31:0]          w_busy;
    logic [31:1]          w_busy_nxt;
    logic                 w_fwd1;
    logic                 w_fwd2;
    logic                 w_src_hz1;
    logic                 w_src_hz2;
    logic                 w_waw_hz;
    logic                 w_slot_free;
    logic                 w_in_ready;
    logic                 w_fire;
    logic [31:0]          w_op1;
    logic [31:0]          w_op2;

    assign w_busy = {r_busy, 1'b0};

`ifdef OPFETCH_BYPASS_EN
    assign w_fwd1 = bus.wb_en && (bus.wb_addr == bus.in_rs1);
    assign w_fwd2 = bus.wb_en && (bus.wb_addr == bus.in_rs2);
`else
    assign w_fwd1 = 1'b0;
    assign w_fwd2 = 1'b0;
`endif

    assign w_src_hz1 = bus.in_rs1_en && (bus.in_rs1 != 5'd0) && w_busy[bus.in_rs1] && !w_fwd1;
    assign w_src_hz2 = bus.in_rs2_en && (bus.in_rs2 != 5'd0) && w_busy[bus.in_rs2] && !w_fwd2;

    // A writer may reuse a pending rd only in the cycle the older write retires.
    assign w_waw_hz = bus.in_rd_en && (bus.in_rd != 5'd0) && w_busy[bus.in_rd]
                      && !(bus.wb_en && (bus.wb_addr == bus.in_rd));

    assign w_slot_free = !r_out_valid || bus.out_ready;
    assign w_in_ready  = w_slot_free && !w_src_hz1 && !w_src_hz2 && !w_waw_hz;
    assign w_fire      = bus.in_valid && w_in_ready;

    assign bus.in_ready    = w_in_ready;
    assign bus.rf_rd_en1   = bus.in_valid && bus.in_rs1_en;
    assign bus.rf_rd_en2   = bus.in_valid && bus.in_rs2_en;
    assign bus.rf_rd_addr1 = bus.in_rs1;
    assign bus.rf_rd_addr2 = bus.in_rs2;

    always_comb begin
        w_op1 = 32'd0;
        w_op2 = 32'd0;
        if (bus.in_rs1_en && (bus.in_rs1 != 5'd0)) begin
            w_op1 = w_fwd1 ? bus.wb_data : bus.rf_rd_data1;
        end
        if (bus.in_rs2_en && (bus.in_rs2 != 5'd0)) begin
            w_op2 = w_fwd2 ? bus.wb_data : bus.rf_rd_data2;
        end
    end

    // Set after clear: a new writer claiming the retiring register keeps it busy.
    always_comb begin
        w_busy_nxt = r_busy;
        for (int i = 1; i < 32; i++) begin
            if (bus.wb_en && (bus.wb_addr == i[4:0])) begin
                w_busy_nxt[i] = 1'b0;
            end
            if (w_fire && bus.in_rd_en && (bus.in_rd == i[4:0])) begin
                w_busy_nxt[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy      <= '0;
            r_out_valid <= 1'b0;
            r_op1       <= 32'd0;
            r_op2       <= 32'd0;
            r_rd        <= 5'd0;
            r_rd_en     <= 1'b0;
            r_payload   <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            if (w_fire) begin
                r_out_valid <= 1'b1;
                r_op1       <= w_op1;
                r_op2       <= w_op2;
                r_rd        <= bus.in_rd;
                r_rd_en     <= bus.in_rd_en;
                r_payload   <= bus.in_payload;
            end else if (r_out_valid && bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.out_valid   = r_out_valid;
    assign bus.out_op1     = r_op1;
    assign bus.out_op2     = r_op2;
    assign bus.out_rd      = r_rd;
    assign bus.out_rd_en   = r_rd_en;
    assign bus.out_payload = r_payload;
endmodule

// File: doc/operand_fetch.md
# operand_fetch

Register-read / issue stage between instruction decode and execute. Drives the read ports of the 32x32 register file, tracks registers with pending writes in a 32-bit scoreboard, stalls on RAW/WAW hazards, and forwards same-cycle writeback data. Issued instructions are held in a single output register with a valid/ready handshake toward execute.

## Interface
- PAYLOAD_W, 32, opaque decoded fields (opcode, funct, imm) passed through unchanged
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  stage accepts the instruction this cycle (combinational)
- in_rs1, in_rs2  in  5 each  source register addresses
- in_rs1_en, in_rs2_en  in  1 each  source used
- in_rd  in  5  destination address
- in_rd_en  in  1  instruction writes in_rd
- in_payload  in  PAYLOAD_W  pass-through fields
- rf_rd_en1, rf_rd_en2  out  1 each  register-file read enables (= in_valid & in_rsN_en)
- rf_rd_addr1, rf_rd_addr2  out  5 each  = in_rs1, in_rs2
- rf_rd_data1, rf_rd_data2  in  32 each  combinational read data (0 when enable low)
- wb_en  in  1  writeback commits this cycle (same signal feeds the register-file write port)
- wb_addr  in  5  writeback address
- wb_data  in  32  writeback data
- out_valid  out  1  instruction held for execute
- out_ready  in  1  execute accepts
- out_op1, out_op2  out  32 each  resolved operands
- out_rd  out  5, out_rd_en  out  1  destination
- out_payload  out  PAYLOAD_W

## Operation
- busy[31:0] scoreboard; busy[0] is constant 0.
- src_hazard(N) = in_rsN_en & in_rsN!=0 & busy[in_rsN] & !(bypass & wb_en & wb_addr==in_rsN).
- waw_hazard = in_rd_en & in_rd!=0 & busy[in_rd] & !(wb_en & wb_addr==in_rd).
- slot_free = !out_valid | out_ready.
- in_ready = slot_free & !src_hazard(1) & !src_hazard(2) & !waw_hazard.
- fire = in_valid & in_ready: output register loads op1/op2, rd, rd_en, payload; out_valid<=1.
- Operand select: if bypass active and wb_en & wb_addr==in_rsN & in_rsN!=0 & in_rsN_en -> wb_data; else rf_rd_dataN.
- Operands for disabled sources are 0; rs=0 always reads 0, never hazards.
- Scoreboard update per edge: clear busy[wb_addr] on wb_en; set busy[in_rd] on fire & in_rd_en & in_rd!=0; set wins when both hit the same address.
- out_valid & out_ready & !fire -> out_valid<=0. Output fields hold stable while out_valid & !out_ready.
- wb_en to a non-busy register is legal and leaves busy unchanged (0).

## Timing
- Reset: out_valid 0, out_op1/op2 0, out_rd 0, out_rd_en 0, out_payload 0, busy all 0. rst mid-operation discards the held instruction and all pending marks in the same edge; in_ready is evaluated from post-reset state next cycle.
- Latency: fire in cycle T -> out_valid in T+1. Throughput 1/cycle when out_ready held high and no hazards.
- Dependent back-to-back instruction stalls until its producer's wb_en cycle (bypass) or the cycle after (no bypass).
- in_ready combinational from in_*, wb_*, out_ready, state; no combinational path from in_valid to in_ready.

## Configuration
- OPFETCH_BYPASS_EN defined: same-cycle writeback forwarding as above; RAW hazard resolves in the wb_en cycle.
- Undefined: no forwarding mux; src_hazard ignores wb_*; operand always rf_rd_dataN; RAW stall lasts one cycle longer. waw_hazard unchanged in both builds.

## Test plan
- Reset, then rd_en=1 rd=5 fire -> next cycle out_valid=1, busy[5]=1; second instr rs1=5 -> in_ready=0 until wb_en wb_addr=5 wb_data=0xDEAD_BEEF; bypass build: fires that cycle with out_op1=0xDEADBEEF; non-bypass: fires one cycle later with same value from regfile.
- rs1=0 rs2=0 with busy all set -> in_ready=1, out_op1=out_op2=0.
- out_ready=0 for 3 cycles with out_valid=1 -> in_ready=0, outputs stable; out_ready=1 with in_valid -> new instr loaded same edge, out_valid stays 1.
- Writer to rd=7 while busy[7]=1 -> WAW stall; wb_en wb_addr=7 same cycle -> fires, busy[7] remains 1.
- Assert rst with out_valid=1 and busy[3]=1 -> next cycle out_valid=0, busy=0, instr with rs1=3 fires immediately.
